// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment display path: segment bit positions,
// the active-low hex glyph table and the all-off pattern.
package seven_segment_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

    // Entry n is the glyph for nibble n; dp (bit 7) is off in every entry.
    localparam logic [15:0][7:0] HEX_GLYPHS = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational nibble-to-segment decoder with decimal point and blanking,
// producing an active-low a..g,dp pattern.
module seven_segment_decoder (
    input  logic [3:0] nibble,
    input  logic       point,
    input  logic       blank,
    output logic [7:0] pattern
);
    import seven_segment_pkg::*;

    always_comb begin
        pattern = HEX_GLYPHS[nibble];
        if (blank) begin
            pattern[SEG_G:SEG_A] = SEG_ALL_OFF[SEG_G:SEG_A];
        end
        pattern[SEG_DP] = ~point;
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment scanner with valid/ready loading,
// frame-boundary display update, leading-zero blanking and PWM brightness.
module seven_segment_scanner #(
    parameter int unsigned DIGITS          = 8,
    parameter int unsigned DIGIT_PERIOD    = 1024,
    parameter int unsigned BRIGHTNESS_BITS = 4
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic [4*DIGITS-1:0]        data,
    input  logic [DIGITS-1:0]          pointEnable,
    input  logic                       dataValid,
    output logic                       dataReady,
    input  logic                       blankLeadingZeros,
    input  logic [BRIGHTNESS_BITS-1:0] brightness,
    output logic [7:0]                 segmentEnableN,
    output logic [DIGITS-1:0]          digitEnableN,
    output logic                       frameStart
);
    import seven_segment_pkg::*;

    localparam int unsigned PW = $clog2(DIGIT_PERIOD);
    localparam int unsigned DW = $clog2(DIGITS);

    logic [PW-1:0]         prescaler;
    logic [DW-1:0]         digit_index;
    logic [4*DIGITS-1:0]   display_data;
    logic [DIGITS-1:0]     display_points;
    logic [4*DIGITS-1:0]   pending_data;
    logic [DIGITS-1:0]     pending_points;
    logic                  pending_full;

    logic                  slot_end;
    logic                  last_digit;
    logic                  frame_boundary;
    logic                  duty_on;
    logic [DIGITS-1:0]     lead_zero;
    logic [DIGITS-1:0]     digit_onehot;
    logic [3:0]            cur_nibble;
    logic [7:0]            cur_pattern;

    assign dataReady      = ~pending_full;
    assign slot_end       = (prescaler == PW'(DIGIT_PERIOD - 1));
    assign last_digit     = (digit_index == DW'(DIGITS - 1));
    assign frame_boundary = slot_end && last_digit;
    assign duty_on        = (prescaler[PW-1 -: BRIGHTNESS_BITS] <= brightness);
    assign cur_nibble     = display_data[{digit_index, 2'b00} +: 4];

    // lead_zero[i]: nibble i and every nibble above it are zero; digit 0 never blanks.
    always_comb begin
        logic higher_zero;
        lead_zero   = '0;
        higher_zero = 1'b1;
        for (int unsigned i = DIGITS - 1; i > 0; i--) begin
            higher_zero  = higher_zero && (display_data[4*i +: 4] == 4'h0);
            lead_zero[i] = higher_zero;
        end
    end

    always_comb begin
        digit_onehot              = '0;
        digit_onehot[digit_index] = 1'b1;
    end

    seven_segment_decoder u_decoder (
        .nibble  (cur_nibble),
        .point   (display_points[digit_index]),
        .blank   (blankLeadingZeros && lead_zero[digit_index]),
        .pattern (cur_pattern)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            prescaler      <= '0;
            digit_index    <= '0;
            display_data   <= '0;
            display_points <= '0;
            pending_data   <= '0;
            pending_points <= '0;
            pending_full   <= 1'b0;
            segmentEnableN <= SEG_ALL_OFF;
            digitEnableN   <= '1;
            frameStart     <= 1'b0;
        end else begin
            if (slot_end) begin
                prescaler   <= '0;
                digit_index <= last_digit ? '0 : digit_index + DW'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            // Transfer needs pending full and acceptance needs it empty, so both never fire together.
            if (frame_boundary && pending_full) begin
                display_data   <= pending_data;
                display_points <= pending_points;
                pending_full   <= 1'b0;
            end else if (dataValid && !pending_full) begin
                pending_data   <= data;
                pending_points <= pointEnable;
                pending_full   <= 1'b1;
            end

            segmentEnableN <= cur_pattern;
            digitEnableN   <= duty_on ? ~digit_onehot : '1;
            frameStart     <= (prescaler == '0) && (digit_index == '0);
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner with DIGITS=4, DIGIT_PERIOD=16,
// BRIGHTNESS_BITS=2; expected slot patterns are queued at load time.
module tb_seven_segment_scanner;

    typedef struct packed {
        logic [3:0] en;
        logic [7:0] seg;
    } slot_t;

    logic        clock;
    logic        resetN;
    logic [15:0] data;
    logic [3:0]  pointEnable;
    logic        dataValid;
    logic        dataReady;
    logic        blankLeadingZeros;
    logic [1:0]  brightness;
    logic [7:0]  segmentEnableN;
    logic [3:0]  digitEnableN;
    logic        frameStart;

    int n_checks = 0;
    int n_fail   = 0;

    slot_t       exp_q[$];
    logic [15:0] mask_q[$];
    slot_t       obs[4];

    seven_segment_scanner #(
        .DIGITS          (4),
        .DIGIT_PERIOD    (16),
        .BRIGHTNESS_BITS (2)
    ) dut (
        .clock             (clock),
        .resetN            (resetN),
        .data              (data),
        .pointEnable       (pointEnable),
        .dataValid         (dataValid),
        .dataReady         (dataReady),
        .blankLeadingZeros (blankLeadingZeros),
        .brightness        (brightness),
        .segmentEnableN    (segmentEnableN),
        .digitEnableN      (digitEnableN),
        .frameStart        (frameStart)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    // Returns at a falling edge where frameStart is high (possibly the current one).
    task automatic wait_frame_start();
        int k;
        for (k = 0; k < 200 && frameStart !== 1'b1; k++) @(negedge clock);
        if (frameStart !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_start_timeout: got frameStart=%b required 1", frameStart);
        end
    endtask

    task automatic capture_frame();
        wait_frame_start();
        obs[0] = '{en: digitEnableN, seg: segmentEnableN};
        for (int d = 1; d < 4; d++) begin
            repeat (16) @(negedge clock);
            obs[d] = '{en: digitEnableN, seg: segmentEnableN};
        end
    endtask

    task automatic do_load(input logic [15:0] value, input logic [3:0] points);
        int k;
        for (k = 0; k < 200 && dataReady !== 1'b1; k++) @(negedge clock);
        if (dataReady !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_ready_timeout: got dataReady=%b required 1", dataReady);
        end
        data        = value;
        pointEnable = points;
        dataValid   = 1'b1;
        @(negedge clock);
        dataValid   = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        exp_q.push_back('{en: 4'hE, seg: s0});
        exp_q.push_back('{en: 4'hD, seg: s1});
        exp_q.push_back('{en: 4'hB, seg: s2});
        exp_q.push_back('{en: 4'h7, seg: s3});
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (segmentEnableN !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_seg: got %h required FF", segmentEnableN);
        end
        n_checks++;
        if (digitEnableN !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_digit: got %h required F", digitEnableN);
        end
        n_checks++;
        if (frameStart !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_frame_start: got %b required 0", frameStart);
        end
        resetN = 1'b1;
        n_checks++;
        if (dataReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", dataReady);
        end
        @(negedge clock);
        n_checks++;
        if (frameStart !== 1'b1) begin
            n_fail++;
            $display("FAIL first_frame_start: got %b required 1", frameStart);
        end
        n_checks++;
        if (digitEnableN !== 4'hE || segmentEnableN !== 8'hC0) begin
            n_fail++;
            $display("FAIL first_slot: got en=%h seg=%h required en=E seg=C0", digitEnableN, segmentEnableN);
        end
    endtask

    task automatic test_scan();
        do_load(16'h1234, 4'b0000);
        n_checks++;
        if (dataReady !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_ready_low: got %b required 0", dataReady);
        end
        push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
        wait_frame_start();
        n_checks++;
        if (dataReady !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_ready_after_boundary: got %b required 1", dataReady);
        end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            slot_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[d] !== e) begin
                n_fail++;
                $display("FAIL scan_digit%0d: got en=%h seg=%h required en=%h seg=%h",
                         d, obs[d].en, obs[d].seg, e.en, e.seg);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        data        = 16'h1111;
        pointEnable = 4'b0000;
        dataValid   = 1'b1;
        @(negedge clock);
        n_checks++;
        if (dataReady !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first_accept: got dataReady=%b required 0", dataReady);
        end
        data = 16'h2222;
        push_frame(8'hF9, 8'hF9, 8'hF9, 8'hF9);
        push_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4);
        for (k = 0; k < 200 && dataReady !== 1'b1; k++) @(negedge clock);
        n_checks++;
        if (dataReady !== 1'b1 || frameStart !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_at_boundary: got ready=%b frameStart=%b required ready=1 frameStart=0",
                     dataReady, frameStart);
        end
        @(negedge clock);
        dataValid = 1'b0;
        n_checks++;
        if (dataReady !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_accept: got dataReady=%b required 0", dataReady);
        end
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            for (int d = 0; d < 4; d++) begin
                slot_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (obs[d] !== e) begin
                    n_fail++;
                    $display("FAIL b2b_frame%0d_digit%0d: got en=%h seg=%h required en=%h seg=%h",
                             f, d, obs[d].en, obs[d].seg, e.en, e.seg);
                end
            end
        end
    endtask

    task automatic test_blanking();
        blankLeadingZeros = 1'b1;
        do_load(16'h0050, 4'b0100);
        push_frame(8'hC0, 8'h92, 8'h7F, 8'hFF);
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            slot_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[d] !== e) begin
                n_fail++;
                $display("FAIL blank_0050_digit%0d: got en=%h seg=%h required en=%h seg=%h",
                         d, obs[d].en, obs[d].seg, e.en, e.seg);
            end
        end
        do_load(16'h0000, 4'b0000);
        push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            slot_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[d] !== e) begin
                n_fail++;
                $display("FAIL blank_0000_digit%0d: got en=%h seg=%h required en=%h seg=%h",
                         d, obs[d].en, obs[d].seg, e.en, e.seg);
            end
        end
        blankLeadingZeros = 1'b0;
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            slot_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[d] !== e) begin
                n_fail++;
                $display("FAIL noblank_digit%0d: got en=%h seg=%h required en=%h seg=%h",
                         d, obs[d].en, obs[d].seg, e.en, e.seg);
            end
        end
    endtask

    task automatic test_brightness();
        logic [1:0] levels [3];
        levels[0] = 2'd0;
        levels[1] = 2'd2;
        levels[2] = 2'd3;
        mask_q.push_back(16'h000F);
        mask_q.push_back(16'h0FFF);
        mask_q.push_back(16'hFFFF);
        for (int l = 0; l < 3; l++) begin
            logic [15:0] mask;
            logic [15:0] e;
            brightness = levels[l];
            @(negedge clock);
            wait_frame_start();
            mask = '0;
            for (int k = 0; k < 16; k++) begin
                mask[k] = (digitEnableN === 4'hE);
                @(negedge clock);
            end
            e = mask_q.pop_front();
            n_checks++;
            if (mask !== e) begin
                n_fail++;
                $display("FAIL brightness%0d_mask: got %h required %h", levels[l], mask, e);
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_reset_mid_slot();
        do_load(16'h1234, 4'b0000);
        capture_frame();
        do_load(16'hABCD, 4'b1111);
        n_checks++;
        if (dataReady !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_pending_full: got dataReady=%b required 0", dataReady);
        end
        #2 resetN = 1'b0;
        #1;
        n_checks++;
        if (segmentEnableN !== 8'hFF || digitEnableN !== 4'hF || frameStart !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async_outputs: got seg=%h en=%h fs=%b required seg=FF en=F fs=0",
                     segmentEnableN, digitEnableN, frameStart);
        end
        @(negedge clock);
        resetN = 1'b1;
        n_checks++;
        if (dataReady !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b required 1", dataReady);
        end
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            slot_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs[d] !== e) begin
                n_fail++;
                $display("FAIL midreset_digit%0d: got en=%h seg=%h required en=%h seg=%h",
                         d, obs[d].en, obs[d].seg, e.en, e.seg);
            end
        end
    endtask

    initial begin
        resetN            = 1'b0;
        data              = '0;
        pointEnable       = '0;
        dataValid         = 1'b0;
        blankLeadingZeros = 1'b0;
        brightness        = 2'd3;
        @(negedge clock);
        test_reset();
        test_scan();
        test_back_to_back();
        test_blanking();
        test_brightness();
        test_reset_mid_slot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
